// File: rtl/vec_mem_pkg.sv
// -----------------------------------------------------------------------------
// vec_mem_pkg
// Shared definitions for the vector memory sequencer: default geometry
// (elements per transfer, element/word width, address width) and the
// sequencer state encoding.
// -----------------------------------------------------------------------------
package vec_mem_pkg;

  localparam int ELEMS_DEF = 16;
  localparam int EW_DEF    = 16;
  localparam int AW_DEF    = 19;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/vec_mem_sequencer.sv
// -----------------------------------------------------------------------------
// vec_mem_sequencer
// Streams a whole vector (ELEMS elements of EW bits) to or from a single-port
// RAM, one element per cycle, starting at base_addr and wrapping modulo 2^AW.
// The pipeline is held in stall while the transfer runs; a one-cycle done
// pulse marks completion.
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-low reset
//   start_read   load request (only looked at in IDLE)
//   start_write  store request (only looked at in IDLE, wins over a load)
//   base_addr    address of element 0, captured with the start
//   rd_tag       destination register tag, captured with start_read
//   wdata_vec    store data, element i at [i*EW +: EW], captured with start
//   mem_addr     RAM address (registered)
//   mem_wdata    RAM write data (registered)
//   mem_wren     RAM write enable (registered)
//   mem_rdata    RAM read data, one cycle after mem_addr
//   stall        combinational pipeline freeze
//   done         registered one-cycle completion pulse
//   rdata_vec    last completed load result
//   rd_tag_out   tag of the load that produced rdata_vec
// -----------------------------------------------------------------------------
module vec_mem_sequencer
  import vec_mem_pkg::*;
#(
  parameter int ELEMS = ELEMS_DEF,
  parameter int EW    = EW_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_read,
  input  logic                start_write,
  input  logic [AW-1:0]       base_addr,
  input  logic [4:0]          rd_tag,
  input  logic [ELEMS*EW-1:0] wdata_vec,
  output logic [AW-1:0]       mem_addr,
  output logic [EW-1:0]       mem_wdata,
  output logic                mem_wren,
  input  logic [EW-1:0]       mem_rdata,
  output logic                stall,
  output logic                done,
  output logic [ELEMS*EW-1:0] rdata_vec,
  output logic [4:0]          rd_tag_out
);

  localparam int            CW   = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ELEMS - 1);

  state_t                state_r, state_s;
  logic [CW-1:0]         cnt_r, cnt_s;
  logic [CW-1:0]         cnt_inc_s, cnt_dec_s;
  logic [ELEMS*EW-1:0]   wbuf_r, wbuf_s;
  logic [ELEMS*EW-1:0]   cap_r, cap_s;
  logic [4:0]            tag_pend_r, tag_pend_s;
  logic [AW-1:0]         mem_addr_r, addr_s;
  logic [EW-1:0]         mem_wdata_r, wdata_s;
  logic                  mem_wren_r, wren_s;
  logic                  done_r, done_s;
  logic [ELEMS*EW-1:0]   rdata_vec_r, rvec_s;
  logic [4:0]            rd_tag_out_r, tag_out_s;

  // cnt_r is the index of the element currently on the RAM port
  assign cnt_inc_s = cnt_r + CW'(1);
  assign cnt_dec_s = cnt_r - CW'(1);

  // Stall covers the request cycle itself so the pipeline never advances
  // past an instruction that has just been accepted.
  assign stall = ((state_r == IDLE) && (start_read || start_write)) ||
                 (state_r == WRITE) || (state_r == READ) || (state_r == DRAIN);

  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign mem_wren   = mem_wren_r;
  assign done       = done_r;
  assign rdata_vec  = rdata_vec_r;
  assign rd_tag_out = rd_tag_out_r;

  // Next-state and next-output logic; RAM port values are computed one cycle
  // ahead so the outputs come straight from flops.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    wbuf_s     = wbuf_r;
    cap_s      = cap_r;
    tag_pend_s = tag_pend_r;
    addr_s     = '0;
    wdata_s    = '0;
    wren_s     = 1'b0;
    done_s     = 1'b0;
    rvec_s     = rdata_vec_r;
    tag_out_s  = rd_tag_out_r;

    case (state_r)
      IDLE: begin
        if (start_write) begin
          state_s = WRITE;
          cnt_s   = '0;
          wbuf_s  = wdata_vec;
          addr_s  = base_addr;
          wdata_s = wdata_vec[EW-1:0];
          wren_s  = 1'b1;
        end else if (start_read) begin
          state_s    = READ;
          cnt_s      = '0;
          tag_pend_s = rd_tag;
          addr_s     = base_addr;
        end else begin
          state_s = IDLE;
        end
      end

      WRITE: begin
        if (cnt_r == LAST) begin
          state_s = DONE;
          done_s  = 1'b1;
        end else begin
          cnt_s   = cnt_inc_s;
          addr_s  = mem_addr_r + AW'(1);
          wdata_s = wbuf_r[cnt_inc_s*EW +: EW];
          wren_s  = 1'b1;
        end
      end

      READ: begin
        // Data for the address issued last cycle arrives now.
        if (cnt_r != '0) begin
          cap_s[cnt_dec_s*EW +: EW] = mem_rdata;
        end else begin
          cap_s = cap_r;
        end
        if (cnt_r == LAST) begin
          state_s = DRAIN;
        end else begin
          cnt_s  = cnt_inc_s;
          addr_s = mem_addr_r + AW'(1);
        end
      end

      DRAIN: begin
        // Last element lands; publish the complete vector only now so an
        // aborted load never disturbs the visible result.
        cap_s[(ELEMS-1)*EW +: EW] = mem_rdata;
        rvec_s    = cap_s;
        tag_out_s = tag_pend_r;
        state_s   = DONE;
        done_s    = 1'b1;
      end

      DONE: begin
        state_s = IDLE;
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counter, buffers and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      wbuf_r       <= '0;
      cap_r        <= '0;
      tag_pend_r   <= 5'd0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      mem_wren_r   <= 1'b0;
      done_r       <= 1'b0;
      rdata_vec_r  <= '0;
      rd_tag_out_r <= 5'd0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      wbuf_r       <= wbuf_s;
      cap_r        <= cap_s;
      tag_pend_r   <= tag_pend_s;
      mem_addr_r   <= addr_s;
      mem_wdata_r  <= wdata_s;
      mem_wren_r   <= wren_s;
      done_r       <= done_s;
      rdata_vec_r  <= rvec_s;
      rd_tag_out_r <= tag_out_s;
    end
  end

endmodule
